// File: rtl/word_uart_tx.sv
// word_uart_tx: snapshots three 6-bit letter codes and sends them as ASCII over UART 8N1.
// Define WORD_UART_TX_CRLF_EN to append CR LF after the third letter.
module word_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [5:0] letter1,
    input  logic [5:0] letter2,
    input  logic [5:0] letter3,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, NEXT = 3'd4;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BMAX = BW'(CLKS_PER_BIT - 1);
`ifdef WORD_UART_TX_CRLF_EN
    localparam int IW = 3;
    localparam logic [IW-1:0] LAST = 3'd4;
`else
    localparam int IW = 2;
    localparam logic [IW-1:0] LAST = 2'd2;
`endif
    logic [2:0]    state;
    logic          send_q;
    logic [BW-1:0] baud;
    logic [2:0]    bit_cnt;
    logic [IW-1:0] idx;
    logic [5:0]    l1, l2, l3;
    logic [7:0]    cur;
    logic          accept, bit_end;

    function automatic logic [7:0] enc(input logic [5:0] c);
        return c < 6'd26 ? 8'h61 + {2'b00, c} : c == 6'h3F ? 8'h20 : 8'h3F;
    endfunction

`ifdef WORD_UART_TX_CRLF_EN
    always_comb cur = idx == 3'd3 ? 8'h0D : idx == 3'd4 ? 8'h0A :
                      enc(idx == 3'd0 ? l1 : idx == 3'd1 ? l2 : l3);
`else
    always_comb cur = enc(idx == 2'd0 ? l1 : idx == 2'd1 ? l2 : l3);
`endif

    assign accept  = send & ~send_q & (state == IDLE);
    assign bit_end = baud == BMAX;
    assign busy    = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            send_q  <= 1'b0;
            baud    <= '0;
            bit_cnt <= '0;
            idx     <= '0;
            l1      <= '0;
            l2      <= '0;
            l3      <= '0;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            send_q <= send;
            done   <= 1'b0;
            baud   <= (state == IDLE || state == NEXT || bit_end) ? '0 : baud + 1'b1;
            case (state)
                IDLE: if (accept) begin
                    l1    <= letter1;
                    l2    <= letter2;
                    l3    <= letter3;
                    idx   <= '0;
                    tx    <= 1'b0;
                    state <= START;
                end
                START: if (bit_end) begin
                    bit_cnt <= '0;
                    tx      <= cur[0];
                    state   <= DATA;
                end
                DATA: if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        tx      <= cur[bit_cnt + 3'd1];
                    end
                end
                // done is registered so it is high exactly during the final NEXT cycle
                STOP: if (bit_end) begin
                    done  <= idx == LAST;
                    state <= NEXT;
                end
                NEXT: if (idx == LAST) begin
                    state <= IDLE;
                end else begin
                    idx   <= idx + 1'b1;
                    tx    <= 1'b0;
                    state <= START;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/word_uart_tx.md
Name: word_uart_tx

Overview:
- Reader and encoder for the three-slot letter buffer.
- On a send request it snapshots the three 6-bit letter codes, maps each code to 8-bit ASCII, and shifts the characters out serially, letter1 first, on a UART 8N1 line.
- Sits between the letter entry logic and the board USB-UART pin so the entered word can be seen on a host terminal.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- send  input  1  transmit request; level input, rising edge detected internally (debounced upstream).
- letter1  input  6  first letter code.
- letter2  input  6  second letter code.
- letter3  input  6  third letter code.
- tx  output  1  UART serial out; idle high.
- busy  output  1  high from accept until the last stop bit ends.
- done  output  1  one-cycle pulse when a word finishes.

Behaviour:
- Reset (async): tx=1, busy=0, done=0, FSM=IDLE, send_q=0, all counters 0.
- Code map, combinational per character:
  - 0..25 -> 0x61..0x7A ('a'..'z').
  - 6'h3F -> 0x20 (space).
  - Any other code -> 0x3F ('?').
- Edge detect: send_q registers send every cycle; accept = send & ~send_q & (state==IDLE).
- A send edge while busy is ignored and is not queued. Holding send high does not retrigger.
- Accept cycle:
  - Snapshot letter1..3 into internal registers. Later input changes do not affect the word in flight.
  - Char index = 0, busy=1 from the next edge.
  - Go to START.
- FSM states:
  - IDLE: tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit counter 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then NEXT.
  - NEXT (1 cycle, tx=1): if index<2, increment and go to START; else assert done for this cycle, go to IDLE.
- busy falls on the same edge that enters IDLE (done cycle included as busy=0? No: busy=1 through NEXT, busy=0 from IDLE).
- Timing:
  - tx goes low on the first clk edge after the accept cycle.
  - Per character: 10*CLKS_PER_BIT cycles + 1 NEXT cycle.
  - Word: 3*(10*CLKS_PER_BIT+1) cycles from the first start bit to IDLE.
- tx is registered (glitch-free). The baud counter counts 0..CLKS_PER_BIT-1 and wraps on the bit boundary.
- Reset mid-frame: tx returns high immediately. The character is truncated; the far end sees a framing error, which is accepted. No resume after reset.
- send and rst deasserting in the same cycle: the edge is seen only if send_q=0 after reset. This is a legal accept.

Optional Feature:
- Macro: WORD_UART_TX_CRLF_EN.
- Defined:
  - After letter3, NEXT continues with two extra characters, 0x0D then 0x0A, using the same framing.
  - Word = 5 characters; done pulses after the LF stop bit.
  - Index counter is 3 bits.
- Undefined: exactly 3 characters, no terminator. Index counter is 2 bits.

Test Plan:
- CLKS_PER_BIT=4, letters 0,1,2, pulse send:
  - tx shows 0x61, 0x62, 0x63 LSB first, each framed 0/…/1.
  - busy high for 123 cycles.
  - done one pulse.
- Letters 6'h3F, 25, 30: characters 0x20, 0x7A, 0x3F.
- Change letter1 from 0 to 5 mid-frame, and pulse send again while busy: word still starts 0x61, exactly one word is sent, no second word follows.
- Hold send high for 500 cycles: exactly one word and one done pulse; a new edge after done starts a second word.
- Assert rst during DATA of the second character: tx=1 and busy=0 in the same cycle. The next send edge transmits the full word from letter1.
- With WORD_UART_TX_CRLF_EN, letters 7,8,4: serial stream 0x68, 0x69, 0x65, 0x0D, 0x0A; busy for 205 cycles at CLKS_PER_BIT=4.
